pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter_if.sv | 29 ++
 rtl/pipe_arbiter.sv | 108 ++++++++++
 tb/tb_pipe_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_arbiter_if.sv
// Bundle of request, pipe and response signals between two requesters, the shared
// delay pipe and the pipe_arbiter. The master side drives requests and pipe_out.
interface pipe_arbiter_if #(
  parameter int W = 8
);
  logic [1:0]   req_vld;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;
  logic [1:0]   req_rdy;
  logic         lock;
  logic         flush;
  logic [W-1:0] pipe_in;
  logic         pipe_in_vld;
  logic [W-1:0] pipe_out;
  logic [1:0]   rsp_vld;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic         flush_done;

  modport master (
    output req_vld, req_data0, req_data1, lock, flush, pipe_out,
    input  req_rdy, pipe_in, pipe_in_vld, rsp_vld, rsp_data, busy, flush_done
  );

  modport slave (
    input  req_vld, req_data0, req_data1, lock, flush, pipe_out,
    output req_rdy, pipe_in, pipe_in_vld, rsp_vld, rsp_data, busy, flush_done
  );
endinterface

// File: rtl/pipe_arbiter.sv
// Two-requester round-robin arbiter in front of a fixed-latency external pipe; a
// tag shift register tracks which requester owns each slot so responses are routed back.
module pipe_arbiter #(
  parameter int W     = 8,
  parameter int DELAY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DELAY + 1);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DELAY-1:0] tag_vld_q;
  logic [DELAY-1:0] tag_own_q;

  logic [1:0]       gnt;
  logic             accept;
  logic             gnt_idx;
  logic             rsp_fire;

  // Grant depends only on req_vld, state, owner and last winner, never on flush/lock.
  always_comb begin
    gnt = 2'b00;
    case (state_q)
      ARB: begin
        if (bus.req_vld == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
        else                      gnt = bus.req_vld;
      end
      LOCKED: begin
        if (owner_q) gnt = {bus.req_vld[1], 1'b0};
        else         gnt = {1'b0, bus.req_vld[0]};
      end
      default: gnt = 2'b00;
    endcase
  end

  assign accept   = |(bus.req_vld & gnt);
  assign gnt_idx  = gnt[1];
  assign rsp_fire = tag_vld_q[DELAY-1];

  assign bus.req_rdy     = gnt;
  assign bus.pipe_in_vld = accept;
  assign bus.pipe_in     = gnt[0] ? bus.req_data0 :
                           gnt[1] ? bus.req_data1 : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (accept && bus.lock) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (!bus.lock || !bus.req_vld[owner_q]) state_d = ARB;
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    // A still-high flush after the pipe empties re-enters DRAIN immediately.
    if (bus.flush) state_d = DRAIN;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_fire && cnt_q != CW'(DELAY)) cnt_d = cnt_q + CW'(1);
    else if (!accept && rsp_fire && cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= {tag_vld_q[DELAY-2:0], accept};
      tag_own_q <= {tag_own_q[DELAY-2:0], gnt_idx};
      if (accept) last_q <= gnt_idx;
    end
  end

  assign bus.rsp_vld    = rsp_fire ? (tag_own_q[DELAY-1] ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data   = bus.pipe_out;
  assign bus.busy       = (cnt_q != '0);
  assign bus.flush_done = (state_q == DRAIN) && (cnt_q == '0);

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter: expected responses are queued at grant time with
// their due cycle and compared when that cycle arrives.
module tb_pipe_arbiter;
  localparam int W     = 8;
  localparam int DELAY = 3;

  logic clk;
  logic rst_n;

  pipe_arbiter_if #(.W(W)) bus ();

  pipe_arbiter #(.W(W), .DELAY(DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External delay pipe model; deliberately not reset.
  logic [W-1:0] dl [DELAY];
  always @(posedge clk) begin
    dl[0] <= bus.pipe_in;
    for (int i = 1; i < DELAY; i++) dl[i] <= dl[i-1];
  end
  assign bus.pipe_out = dl[DELAY-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int           due;
    logic [1:0]   vld;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   drain_m = 0;
  bit   fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", 32'(bus.busy), 32'(sb.size() != 0));
    chk("flush_done", 32'(bus.flush_done), 32'(drain_m && sb.size() == 0));
    if (drain_m && sb.size() == 0) begin
      drain_m = 0;
      fd_seen = 1;
    end
    if (sb.size() != 0 && sb[0].due == cyc) begin
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(sb[0].vld));
      chk("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
      $display("cyc=%0d rsp vld=%b data=%02h", cyc, bus.rsp_vld, bus.rsp_data);
      void'(sb.pop_front());
    end else begin
      chk("rsp_idle", 32'(bus.rsp_vld), 32'd0);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic lk, input logic fl, input logic [1:0] exp_rdy);
    logic [W-1:0] exp_data;
    bus.req_vld   = vld;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.lock      = lk;
    bus.flush     = fl;
    #1;
    exp_data = exp_rdy[0] ? d0 : (exp_rdy[1] ? d1 : '0);
    chk("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    chk("pipe_in_vld", 32'(bus.pipe_in_vld), 32'(exp_rdy != 2'b00));
    chk("pipe_in", 32'(bus.pipe_in), 32'(exp_data));
    $display("cyc=%0d req vld=%b lock=%b flush=%b rdy=%b pipe_in=%02h",
             cyc, vld, lk, fl, bus.req_rdy, bus.pipe_in);
    if (exp_rdy != 2'b00) sb.push_back('{cyc + DELAY, exp_rdy, exp_data});
    if (fl) drain_m = 1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_vld   = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.lock      = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    rst_n = 1'b1;

    // Continuous tie: alternating grants starting with requester 0.
    for (int i = 0; i < 6; i++)
      drive(2'b11, 8'(8'h10 + i), 8'(8'h80 + i), 1'b0, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10);
    idle(DELAY + 1);

    // Single requester 1 with 0xA5; busy covered by tick each cycle.
    drive(2'b10, 8'h00, 8'hA5, 1'b0, 1'b0, 2'b10);
    idle(DELAY + 1);

    // Lock: owner 0 keeps the grant while requesting; requester 1 starved meanwhile.
    drive(2'b11, 8'h20, 8'h90, 1'b1, 1'b0, 2'b01);
    for (int i = 1; i < 4; i++)
      drive(2'b11, 8'(8'h20 + i), 8'(8'h90 + i), 1'b1, 1'b0, 2'b01);
    drive(2'b10, 8'h00, 8'h94, 1'b1, 1'b0, 2'b00);
    drive(2'b10, 8'h00, 8'h95, 1'b1, 1'b0, 2'b10);
    drive(2'b11, 8'h26, 8'h96, 1'b0, 1'b0, 2'b10);
    drive(2'b11, 8'h27, 8'h97, 1'b0, 1'b0, 2'b01);
    idle(DELAY + 1);

    // Flush after four back-to-back accepts; requests held off until the drain ends.
    for (int i = 0; i < 4; i++)
      drive(2'b11, 8'(8'h30 + i), 8'(8'hB0 + i), 1'b0, 1'b0, (i % 2 == 0) ? 2'b10 : 2'b01);
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00);
    fd_seen = 0;
    for (int k = 0; k < 10 && !fd_seen; k++)
      drive(2'b11, 8'h3E, 8'hBE, 1'b0, 1'b0, 2'b00);
    chk("flush_done_seen", 32'(fd_seen), 32'd1);
    drive(2'b11, 8'h3F, 8'hBF, 1'b0, 1'b0, 2'b00);
    drive(2'b11, 8'h40, 8'hC0, 1'b0, 1'b0, 2'b10);
    idle(DELAY + 1);

    // Reset with two transfers in flight; last winner is 0 right before reset.
    drive(2'b10, 8'h00, 8'hD1, 1'b0, 1'b0, 2'b10);
    drive(2'b01, 8'h51, 8'h00, 1'b0, 1'b0, 2'b01);
    bus.req_vld = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", 32'(bus.busy), 32'd0);
    chk("rst2_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    sb.delete();
    drain_m = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    idle(DELAY + 2);
    drive(2'b11, 8'h61, 8'hE1, 1'b0, 1'b0, 2'b01);
    idle(DELAY + 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
